// File: rtl/game_pkg.sv
// Shared game constants: screen geometry, colour palette and the collision
// scanner FSM state type.
package game_pkg;

    localparam int GAME_SCREEN_W = 160;
    localparam int GAME_SCREEN_H = 120;
    localparam int GAME_COLOUR_W = 3;

    localparam logic [GAME_COLOUR_W-1:0] GAME_COLOUR_BACKGROUND = 3'b000;
    localparam logic [GAME_COLOUR_W-1:0] GAME_COLOUR_HAZARD     = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/read_valid_pipe.sv
// DEPTH-stage valid shift register that tracks framebuffer reads in flight.
// The clear input empties every stage on the next edge.
module read_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clock,
    input  logic clear_i,
    input  logic valid_i,
    output logic valid_o
);

    logic [DEPTH-1:0] shift_q;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clock) begin
                if (clear_i) begin
                    shift_q <= '0;
                end else begin
                    shift_q <= valid_i;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clock) begin
                if (clear_i) begin
                    shift_q <= '0;
                end else begin
                    shift_q <= {shift_q[DEPTH-2:0], valid_i};
                end
            end
        end
    endgenerate

    assign valid_o = shift_q[DEPTH-1];

endmodule

// File: rtl/sprite_collision_scanner.sv
// Scans a BOX_W x BOX_H hit-box through the framebuffer read port, counts
// hazard-coloured pixels and maintains sticky collision / screen-end flags.
module sprite_collision_scanner
    import game_pkg::*;
#(
    parameter int                   X_W           = 8,
    parameter int                   Y_W           = 7,
    parameter int                   COLOUR_W      = GAME_COLOUR_W,
    parameter int                   SCREEN_W      = GAME_SCREEN_W,
    parameter int                   SCREEN_H      = GAME_SCREEN_H,
    parameter int                   BOX_W         = 4,
    parameter int                   BOX_H         = 4,
    parameter logic [COLOUR_W-1:0]  HAZARD_COLOUR = GAME_COLOUR_HAZARD,
    parameter int                   GOAL_X        = 156,
    parameter int                   HIT_THRESHOLD = 1,
    parameter int                   READ_LATENCY  = 1
) (
    input  logic                                  clock,
    input  logic                                  resetn,
    input  logic                                  start,
    input  logic [X_W-1:0]                        x_coord,
    input  logic [Y_W-1:0]                        y_coord,
    input  logic                                  clear,
    output logic                                  rd_en,
    output logic [X_W-1:0]                        rd_x,
    output logic [Y_W-1:0]                        rd_y,
    input  logic [COLOUR_W-1:0]                   rd_colour,
    output logic                                  busy,
    output logic                                  done,
    output logic [$clog2(BOX_W*BOX_H+1)-1:0]      hit_count,
    output logic                                  collided,
    output logic                                  reached_screen_end
);

    localparam int N_PIX = BOX_W * BOX_H;
    localparam int HC_W  = $clog2(N_PIX + 1);
    localparam int COL_W = $clog2(BOX_W + 1);
    localparam int ROW_W = $clog2(BOX_H + 1);
    localparam int DR_W  = $clog2(READ_LATENCY + 1);
    localparam int XS_W  = X_W + 1;
    localparam int YS_W  = Y_W + 1;

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(BOX_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(BOX_H - 1);
    localparam logic [DR_W-1:0]  DRAIN_LAST = DR_W'(READ_LATENCY - 1);
    localparam logic [HC_W-1:0]  HIT_MAX    = HC_W'(N_PIX);
    localparam logic [HC_W-1:0]  HIT_THRESH = HC_W'(HIT_THRESHOLD);
    localparam logic [XS_W-1:0]  SCR_W_LIM  = XS_W'(SCREEN_W);
    localparam logic [YS_W-1:0]  SCR_H_LIM  = YS_W'(SCREEN_H);
    localparam logic [XS_W-1:0]  GOAL_LIM   = XS_W'(GOAL_X);

    scan_state_t      state_q, state_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [DR_W-1:0]  drain_q, drain_d;
    logic [HC_W-1:0]  hit_q, hit_d;
    logic             collided_q, collided_d;
    logic             end_q, end_d;

    logic [XS_W-1:0]  pix_x;
    logic [YS_W-1:0]  pix_y;
    logic             in_scan;
    logic             on_screen;
    logic             scan_rd;
    logic             tap_valid;
    logic             accept;
    logic             enter_done;

    // One extra bit keeps x+col / y+row from wrapping back onto the screen.
    assign pix_x     = {1'b0, x_q} + XS_W'(col_q);
    assign pix_y     = {1'b0, y_q} + YS_W'(row_q);
    assign in_scan   = (state_q == ST_SCAN);
    assign on_screen = (pix_x < SCR_W_LIM) && (pix_y < SCR_H_LIM);
    assign scan_rd   = in_scan && on_screen;

    assign rd_en = scan_rd;
    assign rd_x  = in_scan ? pix_x[X_W-1:0] : '0;
    assign rd_y  = in_scan ? pix_y[Y_W-1:0] : '0;

    read_valid_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_read_valid_pipe (
        .clock   (clock),
        .clear_i (!resetn),
        .valid_i (scan_rd),
        .valid_o (tap_valid)
    );

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        col_d      = col_q;
        row_d      = row_q;
        drain_d    = drain_q;
        hit_d      = hit_q;
        collided_d = collided_q;
        end_d      = end_q;
        accept     = 1'b0;
        enter_done = 1'b0;

        if (tap_valid && (rd_colour == HAZARD_COLOUR) && (hit_q != HIT_MAX)) begin
            hit_d = hit_q + HC_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_SCAN;
                    x_d     = x_coord;
                    y_d     = y_coord;
                    col_d   = '0;
                    row_d   = '0;
                    hit_d   = '0;
                end
            end
            ST_SCAN: begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d    = ST_DONE;
                    enter_done = 1'b1;
                end else begin
                    drain_d = drain_q + DR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Setting takes priority over a coincident clear.
        if (clear) begin
            collided_d = 1'b0;
            end_d      = 1'b0;
        end
        if (accept && ({1'b0, x_coord} >= GOAL_LIM)) begin
            end_d = 1'b1;
        end
        if (enter_done && (hit_d >= HIT_THRESH)) begin
            collided_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            drain_q    <= '0;
            hit_q      <= '0;
            collided_q <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            col_q      <= col_d;
            row_q      <= row_d;
            drain_q    <= drain_d;
            hit_q      <= hit_d;
            collided_q <= collided_d;
            end_q      <= end_d;
        end
    end

    assign busy               = (state_q != ST_IDLE);
    assign done               = (state_q == ST_DONE);
    assign hit_count          = hit_q;
    assign collided           = collided_q;
    assign reached_screen_end = end_q;

endmodule

// File: doc/sprite_collision_scanner.md
# sprite_collision_scanner

Parametrised collision/end-of-level detector for the 160x120, 3-bit-colour game framebuffer. On a start pulse it scans a BOX_W x BOX_H hit-box at the sprite position through a framebuffer read port. It counts pixels matching the hazard colour and raises sticky `collided` / `reached_screen_end` flags for the game FSM. It replaces single-pixel colour checking with a pipelined, clipped, thresholded hit-box scan.

## Interface
- `X_W`, default 8: x coordinate width.
- `Y_W`, default 7: y coordinate width.
- `COLOUR_W`, default 3: pixel colour width.
- `SCREEN_W`, default 160: visible width; pixels with x >= SCREEN_W are clipped.
- `SCREEN_H`, default 120: visible height; pixels with y >= SCREEN_H are clipped.
- `BOX_W`, default 4: hit-box width in pixels (>= 1).
- `BOX_H`, default 4: hit-box height in pixels (>= 1).
- `HAZARD_COLOUR`, default 3'b010: colour counted as a hit.
- `GOAL_X`, default 156: end-of-screen threshold.
- `HIT_THRESHOLD`, default 1: minimum hits for a collision (1..BOX_W*BOX_H).
- `READ_LATENCY`, default 1: framebuffer read latency in cycles (>= 1).

Ports:
- `clock`  in  1  clock.
- `resetn`  in  1  reset; synchronous, active-low.
- `start`  in  1  single-cycle request to scan; ignored unless idle.
- `x_coord`  in  X_W  sprite top-left x, sampled with `start`.
- `y_coord`  in  Y_W  sprite top-left y, sampled with `start`.
- `clear`  in  1  clears both sticky flags.
- `rd_en`  out  1  framebuffer read strobe.
- `rd_x`  out  X_W  read x address.
- `rd_y`  out  Y_W  read y address.
- `rd_colour`  in  COLOUR_W  read data, valid READ_LATENCY cycles after `rd_en`.
- `busy`  out  1  high in SCAN, DRAIN and DONE.
- `done`  out  1  one-cycle pulse marking end of scan.
- `hit_count`  out  clog2(BOX_W*BOX_H+1)  hits counted in the last or current scan.
- `collided`  out  1  sticky collision flag.
- `reached_screen_end`  out  1  sticky end flag.

## Operation
- FSM states IDLE, SCAN, DRAIN, DONE.
  - IDLE -> SCAN on `start`.
  - SCAN -> DRAIN after the last hit-box pixel is issued.
  - DRAIN -> DONE once READ_LATENCY cycles have elapsed.
  - DONE -> IDLE unconditionally.
- On `start` in IDLE:
  - capture `x_coord` and `y_coord`;
  - zero `hit_count`;
  - set `reached_screen_end` if captured x >= GOAL_X.
- SCAN visits offsets row-major: column 0..BOX_W-1 inner, row 0..BOX_H-1 outer, one pixel per cycle.
  - `rd_x` = x + col and `rd_y` = y + row, computed one bit wider to avoid wrap.
  - `rd_en` = 1 only if the pixel is on screen; clipped pixels still consume their cycle and are never counted.
- Read tracking: a READ_LATENCY-deep valid shift register follows `rd_en`.
  - When a valid tap arrives and `rd_colour` == HAZARD_COLOUR, `hit_count` increments.
  - `hit_count` saturates at BOX_W*BOX_H.
- On the edge entering DONE:
  - `collided` is set if the final hit count (including any sample arriving that edge) >= HIT_THRESHOLD;
  - `collided` is never cleared by a scan.
- Flags are sticky until `clear` or reset.
  - If `clear` and a set condition occur on the same edge, set wins.
- `start` while `busy` is ignored and not queued.
- Reset, including mid-scan: FSM to IDLE, pipeline emptied, and all outputs 0.
  - Reset values: `rd_en`=0, `rd_x`=0, `rd_y`=0, `busy`=0, `done`=0, `hit_count`=0, `collided`=0, `reached_screen_end`=0.
  - Reads in flight are discarded.

## Timing
- Let N = BOX_W*BOX_H and L = READ_LATENCY, with `start` sampled at the end of cycle k.
- `reached_screen_end` is visible from cycle k+1.
- SCAN occupies cycles k+1..k+N; pixel i (0-based) is addressed in cycle k+1+i.
- DRAIN occupies k+N+1..k+N+L.
- DONE is cycle k+N+L+1:
  - `done`=1;
  - `collided` and `hit_count` are final in that cycle.
- IDLE from k+N+L+2, when the next `start` can be accepted.
- Total busy time is N+L+1 cycles.

## Structure
- A shared package `game_pkg` holds:
  - SCREEN_W and SCREEN_H;
  - the colour constants (HAZARD/background palette);
  - the FSM state enum `scan_state_t`.
- One natural sub-module, `read_valid_pipe`: a parametrised L-deep valid shift register with synchronous clear. Everything else stays in the top level.

## Test plan
- Defaults, all pixels background, `start` at (10,20) -> `rd_en` high in cycles k+1..k+16 with addresses (10..13, 20..23) row-major; `done` at k+18; `hit_count`=0; `collided`=0.
- One HAZARD pixel at (12,21), sprite at (10,20) -> `hit_count`=1 and `collided`=1 in the `done` cycle. Then pulse `clear` -> `collided`=0 next cycle.
- HIT_THRESHOLD=3 with 2 hazard pixels in the box -> `collided` stays 0 and `hit_count`=2; with 3 hazard pixels -> `collided`=1.
- `start` at (157,118) -> `reached_screen_end`=1 at k+1. Only 3x2 = 6 reads are issued; off-screen cycles have `rd_en`=0, and total busy time is still 18 cycles.
- Interference cases:
  - `start` pulsed mid-scan -> ignored, no extra reads.
  - `clear` on the same edge as a collision set -> `collided`=1.
  - `resetn` low mid-SCAN -> all outputs 0 next cycle and no `done` pulse.
- READ_LATENCY=3 with a read model of latency 3 and a hazard on the last pixel -> `done` at k+20 with `collided`=1.
